// File: rtl/tinker_mem_pkg.sv
`default_nettype none
// tinker_mem_pkg: shared op/state types and constants for the Tinker memory responder.
package tinker_mem_pkg;

   localparam int unsigned  TINKER_MEM_SIZE = 524288;
   localparam logic [63:0]  TINKER_RESET_PC = 64'h2000;

   typedef enum logic [1:0] {
      FETCH32 = 2'b00,
      LOAD64  = 2'b01,
      STORE64 = 2'b10,
      RSVD    = 2'b11
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/tinker_mem_responder.sv
`default_nettype none
// tinker_mem_responder: big-endian byte store serving fetch32/load64/store64,
// one byte per cycle, with valid/ready request and response handshakes.
module tinker_mem_responder
   import tinker_mem_pkg::*;
#(
   parameter int MEM_SIZE = TINKER_MEM_SIZE
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(MEM_SIZE);

   logic [7:0] bytes [0:MEM_SIZE-1];

   mem_state_t  state, state_nxt;
   mem_op_t     op_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] shift_q;
   logic [2:0]  cnt;
   logic        err_q;
   logic [63:0] rdata_q;
   logic        rsp_err_q;

   logic [3:0]    req_len;
   logic [64:0]   req_end;
   logic          req_bad;
   logic          last;
   logic [AW-1:0] idx;
   logic [7:0]    rd_byte;
   logic [63:0]   shift_nxt;

   // End address in 65 bits so requests near 2^64 are rejected instead of wrapping.
   always_comb begin
      req_len = (mem_op_t'(req_op) == FETCH32) ? 4'd4 : 4'd8;
      req_end = {1'b0, req_addr} + 65'(req_len) - 65'd1;
      req_bad = (mem_op_t'(req_op) == RSVD) || (req_end >= 65'(MEM_SIZE));
   end

   always_comb begin
      last      = (cnt == ((op_q == FETCH32) ? 3'd3 : 3'd7));
      idx       = AW'(addr_q + 64'(cnt));
      rd_byte   = bytes[idx];
      shift_nxt = {shift_q[55:0], rd_byte};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ACCESS;
         end
         ACCESS: begin
            if (err_q || last) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q      <= FETCH32;
         addr_q    <= 64'd0;
         wdata_q   <= 64'd0;
         shift_q   <= 64'd0;
         cnt       <= 3'd0;
         err_q     <= 1'b0;
         rdata_q   <= 64'd0;
         rsp_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= mem_op_t'(req_op);
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  shift_q <= 64'd0;
                  cnt     <= 3'd0;
                  err_q   <= req_bad;
               end
            end
            ACCESS: begin
               if (err_q) begin
                  rdata_q   <= 64'd0;
                  rsp_err_q <= 1'b1;
               end else begin
                  shift_q <= shift_nxt;
                  cnt     <= cnt + 3'd1;
                  if (last) begin
                     rsp_err_q <= 1'b0;
                     rdata_q   <= (op_q == STORE64) ? 64'd0 : shift_nxt;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rdata_q   <= 64'd0;
                  rsp_err_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // No reset here: the store survives reset, and an aborted store keeps its written bytes.
   always_ff @(posedge clk) begin
      if (state == ACCESS && !err_q && op_q == STORE64)
         bytes[idx] <= wdata_q[{~cnt, 3'b000} +: 8];
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: doc/tinker_mem_responder.md
# tinker_mem_responder

Multi-cycle, handshaked memory responder for the Tinker core. It owns the unified byte-addressed instruction/data store and serves three request types: 32-bit instruction fetch, 64-bit data load and 64-bit data store. Storage is big-endian; `bytes[addr]` is the most significant byte. The block moves one byte per cycle, and a future multi-cycle Tinker core uses it as the far end of its memory port.

## Interface
- `MEM_SIZE`, 524288: number of bytes in the store.
- `clk` input 1: sole clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: initiator presents a request.
- `req_ready` output 1: responder can accept a request.
- `req_op` input 2: 00 fetch32, 01 load64, 10 store64, 11 reserved.
- `req_addr` input 64: byte address of the first (most significant) byte.
- `req_wdata` input 64: store data; ignored for other ops.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: initiator accepts the response.
- `rsp_rdata` output 64: for fetch32, zero-extended in [31:0]; for load64, the full value; for store64 and errors, 0.
- `rsp_err` output 1: request was rejected, with no memory side effect.
- Storage array: `reg [7:0] bytes [0:MEM_SIZE-1]`, named exactly `bytes` so benches can preload and inspect it hierarchically.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid && req_ready`, capture op, addr and wdata. Set byte count n = 4 (fetch32) or 8 (load64/store64), and clear the index counter `cnt` and the read shift register.
- **Error check** at acceptance
  - A request is an error if op==11, or if `req_addr + n - 1 >= MEM_SIZE`.
  - The sum is computed in 65 bits, so addresses near 2^64 are errors and never wrap.
  - On error: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No byte is touched.
- **ACCESS**, one byte per cycle, index `cnt` = 0..n-1
  - Load/fetch: shift register <= {shift[55:0], bytes[addr+cnt]}.
  - Store: bytes[addr+cnt] <= wdata[63-8*cnt -: 8].
  - After the byte with `cnt`==n-1, go to RESP with `rsp_err`=0.
- **RESP**
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `req_ready`=0 in ACCESS and RESP. There is no request queueing and no same-cycle response-to-request bypass.
- Unaligned addresses are legal.
- Reset
  - Outputs reset to `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. State and counter reset to IDLE and 0.
  - Reset does not clear `bytes`.
  - A store aborted by reset leaves exactly the bytes already written (bytes 0..cnt-1) modified.

## Timing
- Request accepted at edge E0.
- Successful access:
  - Byte k is transferred at edge E(k+1).
  - `rsp_valid` rises after edge En: 4 cycles after E0 for fetch32, 8 for load64/store64.
  - Store bytes are fully visible in `bytes` after En.
- Error: `rsp_valid` rises after E1.
- Response accepted at edge Er: `rsp_valid` falls and `req_ready` rises after Er. The next request can be accepted at Er+1 at the earliest.
- Minimum throughput: fetch32 is one request per 6 cycles; load64/store64 one per 10.
- `rsp_ready` held low keeps RESP indefinitely, with outputs stable.
- `req_valid` is ignored outside IDLE.
- Reset asserted mid-ACCESS or mid-RESP forces the reset values immediately and asynchronously. No response is produced for the in-flight request.

## Structure
- Shared package `tinker_mem_pkg`:
  - `mem_op_t` enum: FETCH32, LOAD64, STORE64, RSVD.
  - `mem_state_t` enum: IDLE, ACCESS, RESP.
  - Constant `TINKER_MEM_SIZE` = 524288.
  - Constant `TINKER_RESET_PC` = 64'h2000.
- Single module, no sub-modules. Byte array, FSM, 3-bit `cnt`, 64-bit shift register and captured-request registers are all inline.

## Test plan
- **Fetch32:** preload bytes[0x2000..0x2003]=12 34 56 78; fetch32 @0x2000 -> `rsp_valid` 4 cycles after acceptance, `rsp_rdata`=64'h0000_0000_1234_5678, `rsp_err`=0.
- **Store/load:** store64 @0x100 with wdata 64'h0102_0304_0506_0708 -> bytes[0x100]=01, bytes[0x107]=08, `rsp_rdata`=0. Then load64 @0x101 -> 64'h0203_0405_0607_08xx, where xx = preloaded bytes[0x108].
- **Bounds error:** load64 @MEM_SIZE-7 -> `rsp_err`=1 one cycle after acceptance, no byte changed. load64 @MEM_SIZE-8 succeeds. fetch32 @64'hFFFF_FFFF_FFFF_FFFE -> `rsp_err`=1. op 11 -> `rsp_err`=1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid` -> `rsp_rdata` stable and `req_ready`=0 throughout. `req_valid` pulses during ACCESS/RESP are ignored. Next request is accepted one cycle after the response handshake.
- **Reset mid-store:** store64 @0x200 with wdata all 0xAA, assert reset after 3 byte edges -> bytes[0x200..0x202]=AA, bytes[0x203..0x207] unchanged. Outputs return to reset values immediately.
- **Back-to-back mix:** fetch32, load64, store64 issued back-to-back -> each response matches the order, data and latency rules above.
